// File: rtl/bip_control.sv
// BIP single-cycle processor control unit: program counter, opcode decode to
// datapath/data-memory controls, HLT handling and a saturating cycle counter.
module bip_control #(
  parameter int len_opcode = 5,
  parameter int len_addr   = 11,
  parameter int len_mux_a  = 2,
  parameter int len_count  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [len_opcode-1:0] opcode,
  output logic [len_addr-1:0]   Addr_PC,
  output logic [len_mux_a-1:0]  SelA,
  output logic                  SelB,
  output logic                  WrAcc,
  output logic                  Op,
  output logic                  WrRam,
  output logic                  RdRam,
  output logic                  halted,
  output logic [len_count-1:0]  cycle_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [len_opcode-1:0] OP_HLT  = len_opcode'(5'b00000);
  localparam logic [len_opcode-1:0] OP_STO  = len_opcode'(5'b00001);
  localparam logic [len_opcode-1:0] OP_LD   = len_opcode'(5'b00010);
  localparam logic [len_opcode-1:0] OP_LDI  = len_opcode'(5'b00011);
  localparam logic [len_opcode-1:0] OP_ADD  = len_opcode'(5'b00100);
  localparam logic [len_opcode-1:0] OP_ADDI = len_opcode'(5'b00101);
  localparam logic [len_opcode-1:0] OP_SUB  = len_opcode'(5'b00110);
  localparam logic [len_opcode-1:0] OP_SUBI = len_opcode'(5'b00111);

  localparam logic [len_mux_a-1:0] SELA_MEM = len_mux_a'(2'b00);
  localparam logic [len_mux_a-1:0] SELA_IMM = len_mux_a'(2'b01);
  localparam logic [len_mux_a-1:0] SELA_ALU = len_mux_a'(2'b10);

  localparam logic [len_count-1:0] COUNT_MAX = {len_count{1'b1}};

  logic [0:0]           state_r;
  logic [len_addr-1:0]  pc_r;
  logic [len_count-1:0] count_r;
  logic                 active_s;
  logic                 is_hlt_s;

  // Gating with reset keeps a write from leaking out while reset is low.
  assign active_s = (state_r == ST_RUN) && ena && reset;
  assign is_hlt_s = (opcode == OP_HLT);

  // Combinational decode of the current opcode into datapath/memory controls.
  always_comb begin
    SelA  = SELA_MEM;
    SelB  = 1'b0;
    WrAcc = 1'b0;
    Op    = 1'b0;
    WrRam = 1'b0;
    RdRam = 1'b0;
    if (active_s) begin
      case (opcode)
        OP_STO: WrRam = 1'b1;
        OP_LD: begin
          RdRam = 1'b1;
          WrAcc = 1'b1;
        end
        OP_LDI: begin
          SelA  = SELA_IMM;
          WrAcc = 1'b1;
        end
        OP_ADD: begin
          RdRam = 1'b1;
          SelA  = SELA_ALU;
          WrAcc = 1'b1;
        end
        OP_ADDI: begin
          SelB  = 1'b1;
          SelA  = SELA_ALU;
          WrAcc = 1'b1;
        end
        OP_SUB: begin
          RdRam = 1'b1;
          Op    = 1'b1;
          SelA  = SELA_ALU;
          WrAcc = 1'b1;
        end
        OP_SUBI: begin
          SelB  = 1'b1;
          Op    = 1'b1;
          SelA  = SELA_ALU;
          WrAcc = 1'b1;
        end
        default: begin
          SelA = SELA_MEM;
        end
      endcase
    end else begin
      SelA = SELA_MEM;
    end
  end

  // State, PC and cycle counter; HALT only exits through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      pc_r    <= {len_addr{1'b0}};
      count_r <= {len_count{1'b0}};
    end else if ((state_r == ST_RUN) && ena) begin
      if (count_r != COUNT_MAX) begin
        count_r <= count_r + len_count'(1);
      end else begin
        count_r <= count_r;
      end
      if (is_hlt_s) begin
        state_r <= ST_HALT;
        pc_r    <= pc_r;
      end else begin
        state_r <= ST_RUN;
        pc_r    <= pc_r + len_addr'(1);
      end
    end else begin
      state_r <= state_r;
      pc_r    <= pc_r;
      count_r <= count_r;
    end
  end

  assign Addr_PC     = pc_r;
  assign halted      = (state_r == ST_HALT);
  assign cycle_count = count_r;

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: a program ROM feeds the opcode, a bench-side
// model pushes expected outputs per cycle and the DUT's response is popped against them.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ena = 1'b0;
  logic [4:0]  opcode;
  logic [10:0] Addr_PC;
  logic [1:0]  SelA;
  logic        SelB, WrAcc, Op, WrRam, RdRam, halted;
  logic [31:0] cycle_count;

  logic [4:0]  prog [0:2047];

  typedef struct {
    logic [10:0] pc;
    logic [7:0]  ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_pass = 0;

  logic [10:0] pc_m;
  logic        halt_m;
  logic [31:0] cnt_m;

  bip_control dut (
    .clk(clk), .reset(reset), .ena(ena), .opcode(opcode),
    .Addr_PC(Addr_PC), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc), .Op(Op),
    .WrRam(WrRam), .RdRam(RdRam), .halted(halted), .cycle_count(cycle_count)
  );

  assign opcode = prog[Addr_PC];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // {SelA[1:0], SelB, WrAcc, Op, WrRam, RdRam} straight from the opcode table
  function automatic logic [6:0] table_ctrl(input logic [4:0] opc);
    logic [6:0] r;
    case (opc)
      5'b00001: r = 7'b00_0_0_0_1_0;
      5'b00010: r = 7'b00_0_1_0_0_1;
      5'b00011: r = 7'b01_0_1_0_0_0;
      5'b00100: r = 7'b10_0_1_0_0_1;
      5'b00101: r = 7'b10_1_1_0_0_0;
      5'b00110: r = 7'b10_0_1_1_0_1;
      5'b00111: r = 7'b10_1_1_1_0_0;
      default:  r = 7'b00_0_0_0_0_0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] dut_ctrl();
    return {SelA, SelB, WrAcc, Op, WrRam, RdRam, halted};
  endfunction

  task automatic model_reset();
    pc_m = 11'd0;
    halt_m = 1'b0;
    cnt_m = 32'd0;
  endtask

  // One clock: drive ena at the falling edge, push expectation, compare, then advance model.
  task automatic cycle(input logic en);
    exp_t e;
    exp_t got;
    ena = en;
    e.pc = pc_m;
    e.cnt = cnt_m;
    if (!halt_m && en) e.ctrl = {table_ctrl(prog[pc_m]), 1'b0};
    else e.ctrl = {7'b0000000, halt_m};
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check("pc", {21'd0, Addr_PC}, {21'd0, got.pc});
    check("ctrl", {24'd0, dut_ctrl()}, {24'd0, got.ctrl});
    check("count", cycle_count, got.cnt);
    @(posedge clk);
    if (!halt_m && en) begin
      if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
      if (prog[pc_m] == 5'b00000) halt_m = 1'b1;
      else pc_m = pc_m + 11'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) prog[i] = 5'b11111;
    prog[0] = 5'b00011; prog[1] = 5'b00101; prog[2] = 5'b00001; prog[3] = 5'b00000;

    // reset held: LDI at PC 0 with ena high must not strobe
    #1 reset = 1'b0;
    ena = 1'b1;
    model_reset();
    #3;
    check("rst_pc", {21'd0, Addr_PC}, 32'd0);
    check("rst_ctrl", {24'd0, dut_ctrl()}, 32'd0);
    check("rst_count", cycle_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // LDI; ADDI; STO; HLT then idle in HALT
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check("halt_pc", {21'd0, Addr_PC}, 32'd3);
    check("halt_count", cycle_count, 32'd4);
    check("halted", {31'd0, halted}, 32'd1);

    // HALT ignores ena and a non-HLT opcode
    prog[3] = 5'b00011;
    cycle(1'b0); cycle(1'b1); cycle(1'b0); cycle(1'b1);

    // asynchronous reset between edges
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_halted", {31'd0, halted}, 32'd0);
    check("async_pc", {21'd0, Addr_PC}, 32'd0);
    check("async_count", cycle_count, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // LD; SUB; stall 3 cycles; LDI; ADD; 11111 at PC 4; SUBI; then NOPs to wrap
    prog[0] = 5'b00010; prog[1] = 5'b00110; prog[2] = 5'b00011;
    prog[3] = 5'b00100; prog[4] = 5'b11111; prog[5] = 5'b00111; prog[6] = 5'b01000;
    cycle(1'b1); cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    check("stall_pc", {21'd0, Addr_PC}, 32'd2);
    check("stall_count", cycle_count, 32'd2);
    for (int i = 0; i < 2047; i++) cycle(1'b1);
    check("wrap_pc", {21'd0, Addr_PC}, 32'd1);
    check("wrap_count", cycle_count, 32'd2049);

    // reset pulse in the middle of a STO cycle
    do_reset();
    prog[0] = 5'b00001;
    ena = 1'b1;
    #1;
    check("sto_wrram", {31'd0, WrRam}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("sto_rst_wrram", {31'd0, WrRam}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    ena = 1'b0;
    #1;
    check("sto_rst_pc", {21'd0, Addr_PC}, 32'd0);
    @(negedge clk);
    cycle(1'b1);
    cycle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
